// File: rtl/csam_accum.sv
// csam_accum: frame accumulator placed behind the 8x5 carry-save array multiplier.
// Sums a programmable number of products and presents the total on a valid/ready port.
module csam_accum #(
    parameter int PW = 12,
    parameter int AW = 20,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] sum,
    output logic          overflow
);
    localparam int XW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] acc_r;
    logic [AW-1:0] sum_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] count_r;
    logic          ovf_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          xfer_s;
    logic          last_s;
    logic [XW-1:0] acc_nxt_s;

    // Transfer decode and the one-bit-wider add whose carry feeds overflow
    always_comb begin
        xfer_s    = (state_r == ACCUM) && in_valid;
        last_s    = (count_r == (len_r - LW'(1)));
        acc_nxt_s = {1'b0, acc_r} + XW'(prod);
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len == {LW{1'b0}}) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACCUM);
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    // Accumulator, term counter, result and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= {AW{1'b0}};
            sum_r   <= {AW{1'b0}};
            len_r   <= {LW{1'b0}};
            count_r <= {LW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r   <= len;
                        acc_r   <= {AW{1'b0}};
                        count_r <= {LW{1'b0}};
                        ovf_r   <= 1'b0;
                        if (len == {LW{1'b0}}) begin
                            sum_r <= {AW{1'b0}};
                        end
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        acc_r   <= acc_nxt_s[AW-1:0];
                        ovf_r   <= ovf_r | acc_nxt_s[AW];
                        count_r <= count_r + LW'(1);
                        // Final term: publish the updated total on the same edge
                        if (last_s) begin
                            sum_r <= acc_nxt_s[AW-1:0];
                        end
                    end
                end
                HOLD: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_csam_accum.sv
// Scoreboard bench for csam_accum: default, AW=13 and PW=13 (behind a multiplier model) instances.
module tb_csam_accum;
    logic        clk = 1'b0;
    logic        reset, start, start_m, in_valid, out_ready;
    logic [3:0]  len;
    logic [11:0] prod;
    logic [7:0]  mx;
    logic [4:0]  my;
    logic [12:0] prod_m;
    logic        rdy0, vld0, ovf0, rdy1, vld1, ovf1, rdym, vldm, ovfm;
    logic [19:0] sum0, summ;
    logic [12:0] sum1;

    int n_chk = 0;
    int n_pass = 0;
    logic [20:0] q0[$];
    logic [13:0] q1[$];
    logic [20:0] qm[$];

    always #5 clk = ~clk;

    assign prod_m = 13'(mx) * 13'(my);

    csam_accum u0 (.clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
                   .in_ready(rdy0), .prod(prod), .out_valid(vld0), .out_ready(out_ready),
                   .sum(sum0), .overflow(ovf0));
    csam_accum #(.AW(13)) u1 (.clk(clk), .reset(reset), .start(start), .len(len),
                   .in_valid(in_valid), .in_ready(rdy1), .prod(prod), .out_valid(vld1),
                   .out_ready(out_ready), .sum(sum1), .overflow(ovf1));
    csam_accum #(.PW(13)) u_mac (.clk(clk), .reset(reset), .start(start_m), .len(len),
                   .in_valid(in_valid), .in_ready(rdym), .prod(prod_m), .out_valid(vldm),
                   .out_ready(out_ready), .sum(summ), .overflow(ovfm));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Monitors: pop an expectation on every accepted result
    always @(negedge clk) begin
        logic [20:0] e;
        if (vld0 && out_ready) begin
            if (q0.size() == 0) chk("u0 unexpected result", 1, 0);
            else begin
                e = q0.pop_front();
                chk("u0 sum", sum0, e[19:0]);
                chk("u0 overflow", ovf0, e[20]);
            end
        end
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (vld1 && out_ready) begin
            if (q1.size() == 0) chk("u1 unexpected result", 1, 0);
            else begin
                e = q1.pop_front();
                chk("u1 sum", sum1, e[12:0]);
                chk("u1 overflow", ovf1, e[13]);
            end
        end
    end

    always @(negedge clk) begin
        logic [20:0] e;
        if (vldm && out_ready) begin
            if (qm.size() == 0) chk("mac unexpected result", 1, 0);
            else begin
                e = qm.pop_front();
                chk("mac sum", summ, e[19:0]);
                chk("mac overflow", ovfm, e[20]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit m, input logic [3:0] l);
        if (m) start_m = 1'b1;
        else start = 1'b1;
        len = l;
        step();
        start = 1'b0;
        start_m = 1'b0;
        len = 4'd15;
    endtask

    task automatic put(input bit m, input logic [11:0] p, input logic [7:0] x,
                       input logic [4:0] y, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        prod = p;
        mx = x;
        my = y;
        in_valid = 1'b1;
        while (((m ? rdym : rdy0) == 1'b0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("in_ready timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit m);
        int n = 0;
        while ((m ? vldm : vld0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("out_valid timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  xs[16];
        logic [4:0]  ys[16];
        int          l;
        longint      tot;

        reset = 1'b1; start = 1'b0; start_m = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; len = 4'd0; prod = 12'd0; mx = 8'd0; my = 5'd0;
        repeat (2) step();
        chk("reset in_ready", rdy0, 0);
        chk("reset out_valid", vld0, 0);
        chk("reset sum", sum0, 0);
        chk("reset overflow", ovf0, 0);
        reset = 1'b0;
        step();

        // Basic frame: 100 + 4095 + 1
        q0.push_back({1'b0, 20'd4196});
        q1.push_back({1'b0, 13'd4196});
        go(1'b0, 4'd3);
        put(1'b0, 12'd100, 8'd0, 5'd0, 0);
        put(1'b0, 12'd4095, 8'd0, 5'd0, 0);
        put(1'b0, 12'd1, 8'd0, 5'd0, 0);
        chk("latency out_valid", vld0, 1);
        drain(1'b0);

        // Same frame with bubbles and a stalled consumer
        q0.push_back({1'b0, 20'd4196});
        q1.push_back({1'b0, 13'd4196});
        out_ready = 1'b0;
        go(1'b0, 4'd3);
        put(1'b0, 12'd100, 8'd0, 5'd0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bubble in_ready", rdy0, 1);
        end
        put(1'b0, 12'd4095, 8'd0, 5'd0, 0);
        put(1'b0, 12'd1, 8'd0, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("hold out_valid", vld0, 1);
            chk("hold sum stable", sum0, 4196);
            chk("hold in_ready", rdy0, 0);
            start = (i == 1);
            len = 4'd2;
            in_valid = 1'b1;
            prod = 12'd77;
            step();
        end
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        chk("release out_valid", vld0, 0);
        chk("release ignores start", rdy0, 0);
        step();
        chk("idle in_ready", rdy0, 0);
        chk("idle keeps sum", sum0, 4196);

        // Wrap on AW=13; start pulse in ACCUM must not restart
        q0.push_back({1'b0, 20'd12285});
        q1.push_back({1'b1, 13'd4093});
        go(1'b0, 4'd3);
        put(1'b0, 12'd4095, 8'd0, 5'd0, 0);
        start = 1'b1;
        len = 4'd1;
        step();
        start = 1'b0;
        len = 4'd15;
        put(1'b0, 12'd4095, 8'd0, 5'd0, 0);
        put(1'b0, 12'd4095, 8'd0, 5'd0, 0);
        drain(1'b0);
        q0.push_back({1'b0, 20'd5});
        q1.push_back({1'b0, 13'd5});
        go(1'b0, 4'd1);
        put(1'b0, 12'd5, 8'd0, 5'd0, 0);
        drain(1'b0);

        // Reset after 2 of 4 terms discards the frame at once
        go(1'b0, 4'd4);
        put(1'b0, 12'd7, 8'd0, 5'd0, 0);
        put(1'b0, 12'd9, 8'd0, 5'd0, 0);
        reset = 1'b1;
        #1;
        chk("abort in_ready", rdy0, 0);
        chk("abort out_valid", vld0, 0);
        chk("abort sum", sum0, 0);
        step();
        reset = 1'b0;
        step();
        q0.push_back({1'b0, 20'd30});
        q1.push_back({1'b0, 13'd30});
        go(1'b0, 4'd2);
        put(1'b0, 12'd10, 8'd0, 5'd0, 0);
        put(1'b0, 12'd20, 8'd0, 5'd0, 0);
        drain(1'b0);

        // Zero-length frame with a product on offer
        q0.push_back({1'b0, 20'd0});
        q1.push_back({1'b0, 13'd0});
        in_valid = 1'b1;
        prod = 12'd55;
        go(1'b0, 4'd0);
        chk("len0 out_valid", vld0, 1);
        chk("len0 in_ready", rdy0, 0);
        chk("len0 sum", sum0, 0);
        in_valid = 1'b0;
        drain(1'b0);

        // Multiplier-fed instance: 200*31 twice
        qm.push_back({1'b0, 20'd12400});
        go(1'b1, 4'd2);
        put(1'b1, 12'd0, 8'd200, 5'd31, 0);
        put(1'b1, 12'd0, 8'd200, 5'd31, 1);
        drain(1'b1);

        // Random frames against the reference sum
        for (int f = 0; f < 200; f++) begin
            l = $urandom_range(15, 1);
            tot = 0;
            for (int k = 0; k < l; k++) begin
                xs[k] = 8'($urandom_range(255, 0));
                ys[k] = 5'($urandom_range(31, 0));
                tot += longint'(xs[k]) * longint'(ys[k]);
            end
            qm.push_back({(tot > 64'd1048575) ? 1'b1 : 1'b0, 20'(tot)});
            go(1'b1, 4'(l));
            for (int k = 0; k < l; k++) put(1'b1, 12'd0, xs[k], ys[k], $urandom_range(1, 0));
            drain(1'b1);
        end

        repeat (3) step();
        chk("u0 queue drained", q0.size(), 0);
        chk("u1 queue drained", q1.size(), 0);
        chk("mac queue drained", qm.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
